dcache_sdq: RTL and testbench

- Parametrised store-data queue for the L1 HellaCache miss path.
- Holds store/AMO data words while their requests wait in the MSHRs or the replay queue.
- Hands out entry indices on allocation, serves 1-cycle-latency reads by index at replay, and frees entries by index.
- Additions over the fixed nSDQ=17 scheme:
  - occupancy counter
  - programmable almost-full threshold
  - sticky protocol-error detection

---
 rtl/dcache_sdq_pkg.sv | 41 ++++
 rtl/dcache_sdq_free_finder.sv | 35 +++
 rtl/dcache_sdq.sv | 181 ++++++++++++++++++
 tb/tb_dcache_sdq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_sdq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_sdq_pkg
// Purpose  : Shared sizing helpers and types for the L1 data-cache
//            store-data queue (SDQ) and its lowest-free-entry finder.
// Contents : N_SDQ_DEFAULT      - default entry count (matches core nSDQ)
//            sdq_idx_bits()     - index width for a given entry count
//            sdq_cnt_bits()     - occupancy-counter width for an entry count
//            IDX_BITS/CNT_BITS  - widths for the default entry count
//            sdq_idx_t          - entry index for the default configuration
//            sdq_evt_t          - per-cycle qualified request events
// Revision : 1.0 - initial release
// ============================================================================
package dcache_sdq_pkg;

  // Default queue depth, mirrors DCacheParams::nSDQ of the core.
  localparam int unsigned N_SDQ_DEFAULT = 17;

  function automatic int unsigned sdq_idx_bits(input int unsigned n);
    return $clog2(n);
  endfunction

  // One extra code point so that a completely full queue is representable.
  function automatic int unsigned sdq_cnt_bits(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned IDX_BITS = sdq_idx_bits(N_SDQ_DEFAULT);
  localparam int unsigned CNT_BITS = sdq_cnt_bits(N_SDQ_DEFAULT);

  typedef logic [IDX_BITS-1:0] sdq_idx_t;

  // Requests after qualification against the current valid bitmap.
  typedef struct packed {
    logic alloc_fire;  // alloc_valid while at least one entry is free
    logic free_ok;     // free of an entry that is currently valid
    logic read_hit;    // read_id addresses a currently valid entry
  } sdq_evt_t;

endpackage : dcache_sdq_pkg
`default_nettype wire

// File: rtl/dcache_sdq_free_finder.sv
`default_nettype none
// ============================================================================
// Module   : sdq_free_finder
// Purpose  : Lowest-zero priority encoder over the SDQ valid bitmap.
// Ports    : valid_i    [N_BITS] - entry valid bitmap
//            idx_o      [IDX_W]  - lowest index whose valid bit is 0
//                                  (0 when every entry is valid)
//            any_free_o          - at least one entry is free
// Revision : 1.0 - initial release
// ============================================================================
module sdq_free_finder
  import dcache_sdq_pkg::*;
#(
  parameter  int unsigned N_BITS = N_SDQ_DEFAULT,
  localparam int unsigned IDX_W  = sdq_idx_bits(N_BITS)
) (
  input  logic [N_BITS-1:0] valid_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_free_o
);

  // Scanning from the top down lets the lowest free index win last.
  always_comb begin
    idx_o = '0;
    for (int i = N_BITS - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign any_free_o = ~&valid_i;

endmodule : sdq_free_finder
`default_nettype wire

// File: rtl/dcache_sdq.sv
`default_nettype none
// ============================================================================
// Module   : dcache_sdq
// Purpose  : Store-data queue for the L1 data-cache miss path. Holds store /
//            AMO data while the owning request waits in an MSHR or the replay
//            queue. Allocates the lowest free entry, serves 1-cycle reads by
//            index and frees entries by index. Adds an occupancy counter, an
//            almost-full flag and a sticky protocol-error flag.
// Ports    : clock, reset        - core clock, synchronous active-high reset
//            alloc_valid/ready   - allocate one entry, write alloc_data
//            alloc_data          - data word for the allocated entry
//            alloc_id            - index used by an alloc firing this cycle
//            read_valid/read_id  - read request by entry index
//            resp_valid/resp_data- read response, one cycle after the request
//            free_valid/free_id  - release one entry by index
//            count               - number of valid entries
//            almost_full         - count >= N_SDQ - AF_MARGIN
//            err                 - sticky: read or free of an invalid entry
// Revision : 1.0 - initial release
// ============================================================================
module dcache_sdq
  import dcache_sdq_pkg::*;
#(
  parameter  int unsigned N_SDQ     = N_SDQ_DEFAULT,
  parameter  int unsigned DATA_BITS = 64,
  parameter  int unsigned AF_MARGIN = 2,
  localparam int unsigned IDX_W     = sdq_idx_bits(N_SDQ),
  localparam int unsigned CNT_W     = sdq_cnt_bits(N_SDQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [DATA_BITS-1:0] alloc_data,
  output logic [IDX_W-1:0]     alloc_id,
  input  logic                 read_valid,
  input  logic [IDX_W-1:0]     read_id,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_data,
  input  logic                 free_valid,
  input  logic [IDX_W-1:0]     free_id,
  output logic [CNT_W-1:0]     count,
  output logic                 almost_full,
  output logic                 err
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N_SDQ-1:0]     valid_q, valid_d;
  logic [DATA_BITS-1:0] mem_q [N_SDQ];
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DATA_BITS-1:0] resp_data_q, resp_data_d;
  logic                 err_q, err_d;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_any_free;
  logic [DATA_BITS-1:0] w_read_word;
  sdq_evt_t             w_evt;

  // --------------------------------------------------------------------------
  // Allocation index: lowest free entry of the registered bitmap only, so a
  // free issued this cycle cannot be re-allocated until the next cycle.
  // --------------------------------------------------------------------------
  sdq_free_finder #(
    .N_BITS     (N_SDQ)
  ) u_free_finder (
    .valid_i    (valid_q),
    .idx_o      (w_free_idx),
    .any_free_o (w_any_free)
  );

  assign alloc_ready = w_any_free;
  assign alloc_id    = w_free_idx;

  // --------------------------------------------------------------------------
  // Request qualification. Index decode is done by comparison against every
  // legal entry, so an id >= N_SDQ simply matches nothing and is treated as
  // an invalid entry.
  // --------------------------------------------------------------------------
  always_comb begin
    w_evt            = '0;
    w_read_word      = '0;
    w_evt.alloc_fire = alloc_valid & w_any_free;
    for (int i = 0; i < N_SDQ; i++) begin
      if (read_id == IDX_W'(i)) begin
        w_evt.read_hit = valid_q[i];
        w_read_word    = mem_q[i];
      end
      if (free_id == IDX_W'(i)) begin
        w_evt.free_ok = free_valid & valid_q[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state. Alloc and free can never target the same entry: the alloc
  // index is taken from entries that are invalid now, while a successful free
  // needs an entry that is valid now.
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < N_SDQ; i++) begin
      if (w_evt.alloc_fire && (w_free_idx == IDX_W'(i))) begin
        valid_d[i] = 1'b1;
      end
      if (w_evt.free_ok && (free_id == IDX_W'(i))) begin
        valid_d[i] = 1'b0;
      end
    end

    count_d = count_q + CNT_W'(w_evt.alloc_fire) - CNT_W'(w_evt.free_ok);

    // Reads sample the bitmap before this cycle's free and alloc apply.
    resp_valid_d = read_valid;
    resp_data_d  = resp_data_q;
    if (read_valid) begin
      resp_data_d = w_evt.read_hit ? w_read_word : '0;
    end

    err_d = err_q
          | (read_valid & ~w_evt.read_hit)
          | (free_valid & ~w_evt.free_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  // Data array is deliberately not reset; contents of an invalid entry are
  // never observable because reads of invalid entries return zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_SDQ; i++) begin
      if (!reset && w_evt.alloc_fire && (w_free_idx == IDX_W'(i))) begin
        mem_q[i] <= alloc_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign count      = count_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign err        = err_q;

  generate
    if (AF_MARGIN >= N_SDQ) begin : g_af_const
      assign almost_full = 1'b1;
    end else begin : g_af_cmp
      localparam logic [CNT_W-1:0] c_af_level = CNT_W'(N_SDQ - AF_MARGIN);
      assign almost_full = (count_q >= c_af_level);
    end
  endgenerate

  // Occupancy counter must always agree with the bitmap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (CNT_W'($countones(valid_q)) == count_q);
    end
  end

endmodule : dcache_sdq
`default_nettype wire

// File: tb/tb_dcache_sdq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_sdq
// Purpose  : Self-checking bench for dcache_sdq (N_SDQ=17, AF_MARGIN=2).
//            Read responses are checked by a monitor against a queue of
//            expected data; control outputs are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_sdq;

  localparam int unsigned N_SDQ     = 17;
  localparam int unsigned DATA_BITS = 64;
  localparam int unsigned AF_MARGIN = 2;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned CNT_W     = 5;

  logic                 clk;
  logic                 rst;
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [DATA_BITS-1:0] alloc_data;
  logic [IDX_W-1:0]     alloc_id;
  logic                 read_valid;
  logic [IDX_W-1:0]     read_id;
  logic                 resp_valid;
  logic [DATA_BITS-1:0] resp_data;
  logic                 free_valid;
  logic [IDX_W-1:0]     free_id;
  logic [CNT_W-1:0]     count;
  logic                 almost_full;
  logic                 err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_BITS-1:0] exp_q [$];

  dcache_sdq #(
    .N_SDQ       (N_SDQ),
    .DATA_BITS   (DATA_BITS),
    .AF_MARGIN   (AF_MARGIN)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_data  (alloc_data),
    .alloc_id    (alloc_id),
    .read_valid  (read_valid),
    .read_id     (read_id),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .free_valid  (free_valid),
    .free_id     (free_id),
    .count       (count),
    .almost_full (almost_full),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp_unexpected: got data 0x%0h expected no response", resp_data);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", resp_data, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_data  = '0;
    read_valid  = 1'b0;
    read_id     = '0;
    free_valid  = 1'b0;
    free_id     = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic alloc_one(input logic [63:0] d, input int exp_id);
    alloc_valid = 1'b1;
    alloc_data  = d;
    #1;
    check("alloc_ready", alloc_ready, 1);
    check("alloc_id", alloc_id, exp_id);
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // ---- Reset state ----
    do_reset();
    #1;
    check("rst_count", count, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_id", alloc_id, 0);
    check("rst_almost_full", almost_full, 0);
    check("rst_err", err, 0);
    check("rst_resp_valid", resp_valid, 0);

    // ---- Fill all 17 entries, almost_full from count 15 ----
    for (int i = 0; i < 17; i++) begin
      alloc_valid = 1'b1;
      alloc_data  = 64'h100 + 64'(i);
      #1;
      check("fill_alloc_id", alloc_id, i);
      check("fill_count", count, i);
      check("fill_almost_full", almost_full, (i >= 15) ? 1 : 0);
      step();
      idle();
    end
    #1;
    check("full_count", count, 17);
    check("full_alloc_ready", alloc_ready, 0);
    check("full_alloc_id", alloc_id, 0);
    check("full_almost_full", almost_full, 1);

    // ---- Full: free 5 with alloc in same cycle -> alloc ignored ----
    free_valid  = 1'b1;
    free_id     = 5'd5;
    alloc_valid = 1'b1;
    alloc_data  = 64'hDEAD;
    #1;
    check("full_free_ready", alloc_ready, 0);
    step();
    idle();
    #1;
    check("after_free_count", count, 16);
    check("after_free_ready", alloc_ready, 1);
    check("after_free_id", alloc_id, 5);
    alloc_one(64'hABC, 5);
    read_valid = 1'b1;
    read_id    = 5'd5;
    exp_q.push_back(64'hABC);
    step();
    read_id    = 5'd6;
    exp_q.push_back(64'h106);
    step();
    idle();
    #1;
    check("fullpath_err", err, 0);
    check("fullpath_count", count, 17);

    // ---- Simultaneous alloc and free on distinct entries ----
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(64'h200 + 64'(i), i);
    alloc_valid = 1'b1;
    alloc_data  = 64'h300;
    free_valid  = 1'b1;
    free_id     = 5'd2;
    #1;
    check("af_alloc_id", alloc_id, 4);
    step();
    idle();
    #1;
    check("af_count", count, 4);
    check("af_next_id", alloc_id, 2);
    read_valid = 1'b1;
    read_id    = 5'd4;
    exp_q.push_back(64'h300);
    step();
    idle();

    // ---- Read-before-free on entry 7, then read of freed entry ----
    alloc_one(64'h402, 2);
    alloc_one(64'h405, 5);
    alloc_one(64'h406, 6);
    alloc_one(64'h407, 7);
    #1;
    check("rf_count_before", count, 8);
    read_valid = 1'b1;
    read_id    = 5'd7;
    free_valid = 1'b1;
    free_id    = 5'd7;
    exp_q.push_back(64'h407);
    step();
    idle();
    #1;
    check("rf_err_clean", err, 0);
    check("rf_count_after", count, 7);
    read_valid = 1'b1;
    read_id    = 5'd7;
    exp_q.push_back(64'h0);
    step();
    idle();
    #1;
    check("rinv_err", err, 1);
    step();
    #1;
    check("rinv_err_sticky", err, 1);

    // ---- Free of out-of-range id 20 ----
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(64'h500 + 64'(i), i);
    free_valid = 1'b1;
    free_id    = 5'd20;
    step();
    idle();
    #1;
    check("oor_count", count, 3);
    check("oor_alloc_id", alloc_id, 3);
    check("oor_err", err, 1);

    // ---- Free of invalid in-range id 9 ----
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(64'h600 + 64'(i), i);
    free_valid = 1'b1;
    free_id    = 5'd9;
    step();
    idle();
    #1;
    check("inv_count", count, 3);
    check("inv_alloc_id", alloc_id, 3);
    check("inv_err", err, 1);
    read_valid = 1'b1;
    read_id    = 5'd20;
    exp_q.push_back(64'h0);
    step();
    idle();

    // ---- Reset mid-operation with everything active ----
    do_reset();
    for (int i = 0; i < 10; i++) alloc_one(64'h700 + 64'(i), i);
    free_valid = 1'b1;
    free_id    = 5'd15;
    step();
    idle();
    #1;
    check("pre_rst_err", err, 1);
    check("pre_rst_count", count, 10);
    rst         = 1'b1;
    alloc_valid = 1'b1;
    alloc_data  = 64'hFFFF;
    read_valid  = 1'b1;
    read_id     = 5'd3;
    free_valid  = 1'b1;
    free_id     = 5'd4;
    step();
    rst = 1'b0;
    idle();
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_alloc_id", alloc_id, 0);
    check("mid_rst_almost_full", almost_full, 0);

    // ---- Drain: every expected response must have arrived ----
    step();
    step();
    check("resp_outstanding", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dcache_sdq
`default_nettype wire
